if_id_pipe_reg: RTL and testbench



---
 rtl/if_id_pipe_reg.sv | 128 ++++++++++++
 tb/tb_if_id_pipe_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: two-entry skid FIFO with valid/ready handshake, flush and NOP bubbles.
// State updates on the falling clock edge. Define IF_ID_PERF_EN to add the stall_count counter.
module if_id_pipe_reg #(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = {INSTR_W{1'b0}}
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instruction,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instruction
`ifdef IF_ID_PERF_EN
  ,
  output logic [15:0]        stall_count
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    head_pc_q, head_pc_d;
  logic [INSTR_W-1:0] head_instr_q, head_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               accept, drain;

  // Handshake flags come from registered state only, so no input reaches an output combinationally.
  assign in_ready        = (state_q != StTwo);
  assign out_valid       = (state_q != StEmpty);
  assign out_pc          = head_pc_q;
  assign out_instruction = head_instr_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      // Incoming entry is dropped; out_pc keeps its last value.
      state_d      = StEmpty;
      head_instr_d = NOP_INSTR;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d      = StOne;
            head_pc_d    = in_pc;
            head_instr_d = in_instruction;
          end
        end
        StOne: begin
          if (accept && drain) begin
            head_pc_d    = in_pc;
            head_instr_d = in_instruction;
          end else if (accept) begin
            state_d      = StTwo;
            skid_pc_d    = in_pc;
            skid_instr_d = in_instruction;
          end else if (drain) begin
            state_d      = StEmpty;
            head_instr_d = NOP_INSTR;
          end
        end
        StTwo: begin
          if (drain) begin
            state_d      = StOne;
            head_pc_d    = skid_pc_q;
            head_instr_d = skid_instr_q;
          end
        end
        default: begin
          state_d      = StEmpty;
          head_instr_d = NOP_INSTR;
        end
      endcase
    end
  end

  always_ff @(negedge clock) begin
    if (!reset_n) begin
      state_q      <= StEmpty;
      head_pc_q    <= '0;
      head_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

`ifdef IF_ID_PERF_EN
  logic [15:0] stall_q, stall_d;

  // Saturating; flush does not clear it.
  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(negedge clock) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg: a reference FIFO queue predicts every output.
// Inputs change on the rising edge and outputs are checked on the rising edge (DUT uses falling).
module tb_if_id_pipe_reg;

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_instruction, out_pc, out_instruction;
`ifdef IF_ID_PERF_EN
  logic [15:0] stall_count;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  entry_t      sb_q[$];
  logic [31:0] last_pc;
  logic [15:0] stall_exp;

  always #5 clock = ~clock;

  if_id_pipe_reg #(
    .PC_W      (32),
    .INSTR_W   (32),
    .NOP_INSTR (Nop)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_instruction  (in_instruction),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instruction (out_instruction)
`ifdef IF_ID_PERF_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
    check_eq("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
    if (sb_q.size() > 0) begin
      check_eq("out_pc", 64'(out_pc), 64'(sb_q[0].pc));
      check_eq("out_instr", 64'(out_instruction), 64'(sb_q[0].instr));
    end else begin
      check_eq("out_pc_hold", 64'(out_pc), 64'(last_pc));
      check_eq("out_instr_nop", 64'(out_instruction), 64'(Nop));
    end
`ifdef IF_ID_PERF_EN
    check_eq("stall_count", 64'(stall_count), 64'(stall_exp));
`endif
  endtask

  // One cycle: check outputs, drive inputs, then advance the model across the falling edge.
  task automatic step(input logic rst_n, input logic v, input logic [31:0] pc,
                      input logic [31:0] instr, input logic ordy, input logic fl);
    logic acc, drn;
    @(posedge clock);
    check_outputs();
    reset_n        = rst_n;
    in_valid       = v;
    in_pc          = pc;
    in_instruction = instr;
    out_ready      = ordy;
    flush          = fl;
    @(negedge clock);
    acc = v && (sb_q.size() < 2);
    drn = ordy && (sb_q.size() > 0);
    if (!rst_n) begin
      sb_q.delete();
      last_pc   = '0;
      stall_exp = '0;
    end else begin
      if (v && sb_q.size() == 2 && stall_exp != 16'hFFFF) stall_exp++;
      if (fl) begin
        sb_q.delete();
      end else begin
        if (drn) void'(sb_q.pop_front());
        if (acc) sb_q.push_back('{pc: pc, instr: instr});
      end
      if (sb_q.size() > 0) last_pc = sb_q[0].pc;
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, ordy, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b1; in_pc = 32'h55; in_instruction = 32'h55;
    out_ready = 1'b0; flush = 1'b0;
    last_pc = '0; stall_exp = '0;
    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    sb_q.delete();
    // Reset held for two edges with in_valid high; checked at the next step.
    step(1'b0, 1'b1, 32'h77, 32'h77, 1'b0, 1'b0);

    // Streaming
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(i), 32'hA0 + 32'(i), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Stall / skid
    step(1'b1, 1'b1, 32'd4, 32'hA4, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd5, 32'hA5, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd6, 32'hA6, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd6, 32'hA6, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'd6, 32'hA6, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Flush in TWO with a simultaneous input
    step(1'b1, 1'b1, 32'd8, 32'hA8, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd9, 32'hA9, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd10, 32'hAA, 1'b0, 1'b1);
    idle(1'b0);
    step(1'b1, 1'b1, 32'd12, 32'hAC, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Reset beats flush in ONE
    step(1'b1, 1'b1, 32'd14, 32'hAE, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'd15, 32'hAF, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

`ifdef IF_ID_PERF_EN
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd20, 32'hB0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd21, 32'hB1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'd22, 32'hB2, 1'b0, 1'b0);
    @(posedge clock);
    check_eq("stall_count_5", 64'(stall_count), 64'd5);
    for (int i = 0; i < 70000; i++) step(1'b1, 1'b1, 32'd22, 32'hB2, 1'b0, 1'b0);
    @(posedge clock);
    check_eq("stall_count_sat", 64'(stall_count), 64'hFFFF);
`endif

    @(posedge clock);
    check_outputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
